// File: rtl/riscv_pkg.sv
// Shared definitions for the boot loader: header width, word width and
// the sequencer state encoding.
package riscv_pkg;

    localparam int HDR_W  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        LEN0  = 3'd0,
        LEN1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4,
        RUN   = 3'd5,
        ERR   = 3'd6
    } boot_state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles accepted bytes little-endian into a 32-bit word and flags the
// cycle in which the fourth byte of a word is accepted.
module byte_packer
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              accept_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (accept_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o      = word_q;
    assign word_done_o = accept_i && (idx_q == 2'd3);

endmodule

// File: rtl/boot_sequencer.sv
// Loads a length-prefixed byte stream into instruction memory, holds the
// CPU in reset while loading and for RESET_HOLD cycles after, then releases it.
module boot_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned RESET_HOLD  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              boot_done,
    output logic              boot_err,
    output boot_state_e       dbg_state
);

    // Valid/ready: a byte transfers on a rising edge where rx_valid && rx_ready;
    // rx_ready depends only on the current state, never on rx_valid.

    localparam int WIDX_W = $clog2(DEPTH_WORDS + 1);
    localparam int HOLD_W = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);
    localparam logic [HDR_W-1:0]  DEPTH16   = HDR_W'(DEPTH_WORDS);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);

    boot_state_e        state_q, state_d;
    logic [HDR_W-1:0]   count_q, count_d;
    logic [WIDX_W-1:0]  widx_q, widx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HDR_W-1:0]   widx_next;
    logic               pack_accept;
    logic               word_done;
    logic [WORD_W-1:0]  word;

    assign pack_accept = rx_valid && (state_q == DATA);
    assign widx_next   = HDR_W'(widx_q) + HDR_W'(1);

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .accept_i    (pack_accept),
        .byte_i      (rx_data),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        widx_d     = widx_q;
        hold_d     = hold_q;
        rx_ready   = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        cpu_reset  = 1'b1;
        boot_done  = 1'b0;
        boot_err   = 1'b0;

        case (state_q)
            LEN0: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    count_d[7:0] = rx_data;
                    state_d      = LEN1;
                end
            end
            LEN1: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    count_d = {rx_data, count_q[7:0]};
                    if (count_d == '0) begin
                        state_d = HOLD;
                        hold_d  = HOLD_INIT;
                    end else if (count_d > DEPTH16) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (word_done) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                imem_we    = 1'b1;
                imem_addr  = 32'(widx_q) << 2;
                imem_wdata = word;
                widx_d     = widx_q + WIDX_W'(1);
                if (widx_next == count_q) begin
                    state_d = HOLD;
                    hold_d  = HOLD_INIT;
                end else begin
                    state_d = DATA;
                end
            end
            HOLD: begin
                // Exactly RESET_HOLD cycles in HOLD (at least one).
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            RUN: begin
                cpu_reset = 1'b0;
                boot_done = 1'b1;
            end
            ERR: begin
                boot_err = 1'b1;
            end
            default: begin
                state_d = LEN0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LEN0;
            count_q <= '0;
            widx_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            hold_q  <= hold_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: transaction-level model checked every
// cycle, plus literal write/timing expectations per scenario.
module tb_boot_sequencer;
    import riscv_pkg::*;

    localparam int DEPTH = 64;
    localparam int HOLD  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        boot_done;
    logic        boot_err;
    boot_state_e dbg_state;

    always #5 clk = ~clk;

    boot_sequencer #(.DEPTH_WORDS(DEPTH), .RESET_HOLD(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .boot_done  (boot_done),
        .boot_err   (boot_err),
        .dbg_state  (dbg_state)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] exp_q[$];   // {addr, data} of each write still expected
    logic [7:0]  tx_q[$];    // bytes the driver will send next

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- model and per-cycle compare ----------------
    int          cyc = 0;
    int          acc_cnt, we_cnt, last_we_cyc, last_acc_cyc, done_cyc;
    int          m_phase;    // 0 loading, 1 load complete, 2 bad header
    int          m_nhdr, m_nb, m_widx, m_since;
    bit          m_pend;
    logic [15:0] m_count;
    logic [31:0] m_word, m_pend_word;

    always @(negedge clk) begin
        bit          exp_done;
        bit          nxt_pend;
        logic [63:0] exp_w;
        cyc++;
        if (reset) begin
            m_phase = 0; m_nhdr = 0; m_nb = 0; m_widx = 0; m_since = 0;
            m_pend = 1'b0; m_count = '0; m_word = '0; m_pend_word = '0;
            acc_cnt = 0; we_cnt = 0; last_we_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
        end else begin
            exp_done = (m_phase == 1) && (m_since >= HOLD);
            check("rx_ready",   rx_ready,   (m_phase == 0) && !m_pend);
            check("imem_we",    imem_we,    m_pend);
            check("imem_addr",  imem_addr,  m_pend ? 32'(m_widx * 4) : 32'h0);
            check("imem_wdata", imem_wdata, m_pend ? m_pend_word : 32'h0);
            check("cpu_reset",  cpu_reset,  !exp_done);
            check("boot_done",  boot_done,  exp_done);
            check("boot_err",   boot_err,   m_phase == 2);
            if (imem_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_write: got write addr 0x%0h data 0x%0h, expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({imem_addr, imem_wdata} !== exp_w) begin
                        tests_failed++;
                        $display("FAIL sb_write: got 0x%0h, expected 0x%0h", {imem_addr, imem_wdata}, exp_w);
                    end
                end
            end
            if (boot_done && done_cyc < 0) done_cyc = cyc;

            if (m_phase == 1) begin
                m_since++;
            end else if (m_phase == 0) begin
                nxt_pend = 1'b0;
                if (!m_pend && rx_valid) begin
                    acc_cnt++;
                    last_acc_cyc = cyc;
                    if (m_nhdr < 2) begin
                        m_count[8*m_nhdr +: 8] = rx_data;
                        m_nhdr++;
                        if (m_nhdr == 2) begin
                            if (m_count == 0) begin
                                m_phase = 1; m_since = 0;
                            end else if (m_count > DEPTH) begin
                                m_phase = 2;
                            end
                        end
                    end else begin
                        m_word[8*m_nb +: 8] = rx_data;
                        m_nb++;
                        if (m_nb == 4) begin
                            m_nb = 0;
                            nxt_pend = 1'b1;
                            m_pend_word = m_word;
                        end
                    end
                end
                if (m_pend) begin
                    m_widx++;
                    if (m_widx == m_count) begin
                        m_phase = 1; m_since = 0;
                    end
                end
                m_pend = nxt_pend;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte: byte 0x%0h not accepted in 40 cycles, expected acceptance", b);
        end
        rx_valid = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid 1-0-0-1 pattern, 2: varied gaps
    task automatic send_all(input int mode);
        int i = 0;
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front(), (mode == 1) ? ((i % 2 == 1) ? 2 : 0) : (mode == 2) ? (i % 5) : 0);
            i++;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!boot_done && n < budget) begin @(posedge clk); #1; n++; end
        check("wait_done", boot_done, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic load_two_words();
        tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        exp_q.push_back({32'h0000_0000, 32'h00A0_0513});
        exp_q.push_back({32'h0000_0004, 32'h00B0_0593});
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        do_reset();
        check("reset_rx_ready",  rx_ready,   1'b1);
        check("reset_cpu_reset", cpu_reset,  1'b1);
        check("reset_imem_we",   imem_we,    1'b0);
        check("reset_addr",      imem_addr,  32'h0);
        check("reset_wdata",     imem_wdata, 32'h0);
        check("reset_boot_done", boot_done,  1'b0);
        check("reset_boot_err",  boot_err,   1'b0);
        check("reset_state",     dbg_state,  LEN0);

        // Two words back-to-back; valid stays high across each WRITE cycle.
        load_two_words();
        send_all(0);
        wait_done(50);
        check("two_words_writes",   we_cnt, 2);
        check("two_words_sb_empty", exp_q.size(), 0);
        check("two_words_accepted", acc_cnt, 10);
        check("two_words_release",  done_cyc - last_we_cyc, HOLD + 1);
        rx_valid = 1'b1; rx_data = 8'hFF;
        repeat (5) begin @(posedge clk); #1; end
        rx_valid = 1'b0;
        check("run_ignores_ready", rx_ready, 1'b0);
        check("run_ignores_cnt",   acc_cnt, 10);
        check("run_still_done",    boot_done, 1'b1);

        // Reset out of RUN, then zero-length header.
        do_reset();
        check("rerun_cpu_reset", cpu_reset, 1'b1);
        check("rerun_boot_done", boot_done, 1'b0);
        check("rerun_rx_ready",  rx_ready,  1'b1);
        tx_q = '{8'h00, 8'h00};
        send_all(0);
        wait_done(50);
        check("zero_len_writes",  we_cnt, 0);
        check("zero_len_release", done_cyc - last_acc_cyc, HOLD + 1);

        // Oversize header 65 > 64.
        do_reset();
        tx_q = '{8'h41, 8'h00};
        send_all(0);
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (4) begin @(posedge clk); #1; end
        rx_valid = 1'b0;
        check("oversize_err",       boot_err,  1'b1);
        check("oversize_rx_ready",  rx_ready,  1'b0);
        check("oversize_cpu_reset", cpu_reset, 1'b1);
        check("oversize_state",     dbg_state, ERR);
        check("oversize_writes",    we_cnt, 0);

        // Sparse stream, same expected writes.
        do_reset();
        load_two_words();
        send_all(1);
        wait_done(50);
        check("sparse_writes",   we_cnt, 2);
        check("sparse_sb_empty", exp_q.size(), 0);

        // Reset after two data bytes: the partial word must never be written.
        do_reset();
        tx_q = '{8'h02, 8'h00, 8'h13, 8'h05};
        send_all(0);
        repeat (3) begin @(posedge clk); #1; end
        check("partial_no_write", we_cnt, 0);
        do_reset();
        load_two_words();
        send_all(0);
        wait_done(50);
        check("after_partial_writes",   we_cnt, 2);
        check("after_partial_sb_empty", exp_q.size(), 0);

        // Three words with varied gaps.
        do_reset();
        tx_q = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'h01, 8'h00, 8'h00, 8'h80};
        exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        exp_q.push_back({32'h0000_0004, 32'h1234_5678});
        exp_q.push_back({32'h0000_0008, 32'h8000_0001});
        send_all(2);
        wait_done(50);
        check("three_words_writes",   we_cnt, 3);
        check("three_words_sb_empty", exp_q.size(), 0);

        // Count exactly DEPTH words fills the memory.
        do_reset();
        tx_q = '{8'h40, 8'h00};
        for (int k = 0; k < 4 * DEPTH; k++) tx_q.push_back(8'(k));
        for (int w = 0; w < DEPTH; w++)
            exp_q.push_back({32'(4 * w), 8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
        send_all(0);
        wait_done(100);
        check("full_depth_writes",   we_cnt, DEPTH);
        check("full_depth_sb_empty", exp_q.size(), 0);
        check("full_depth_err",      boot_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
